// File: rtl/seq_detector_param_pkg.sv
// seqdet_pkg: shared types, reset constants and width helper for the pattern detector
package seqdet_pkg;
  typedef enum logic {OVL_OFF = 1'b0, OVL_ON = 1'b1} ovl_e;
  localparam logic [7:0] RST_PATTERN = 8'b0000_0101;
  localparam int RST_LEN = 3;
  localparam logic RST_OVERLAP = 1'b1;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream, configuration and status bundle for the detector
interface seq_detector_param_if
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = len_w(MAX_LEN);
  logic in_valid;
  logic in_bit;
  logic cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
  logic count_clear;
  logic match;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] Estado;
  modport master(
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clear,
    input match, match_count, Estado
  );
  modport slave(
    input in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clear,
    output match, match_count, Estado
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: saturating up-counter; clear together with inc restarts at one
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clear) count <= W'(inc);
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable Moore serial-pattern detector with saturating match counter
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(RST_PATTERN),
  parameter int DEF_LEN = RST_LEN,
  parameter logic DEF_OVERLAP = RST_OVERLAP
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);
  localparam int LEN_W = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  logic [MAX_LEN-1:0] hist, hist_nx, pat, pat_nx, mask, shifted;
  logic [LEN_W-1:0] len, len_nx, fill, fill_nx, cfg_len_c;
  ovl_e ovl, ovl_nx;
  logic match_q, match_nx, acc, hit;
  assign acc = bus.in_valid & ~bus.cfg_load;
  assign cfg_len_c = bus.cfg_len == '0 ? LEN_W'(1) : (bus.cfg_len > LEN_MAX ? LEN_MAX : bus.cfg_len);
  assign mask = {MAX_LEN{1'b1}} >> (LEN_MAX - len);
  assign shifted = {hist[MAX_LEN-2:0], bus.in_bit};
  // fill gates the compare so stale history bits never complete a match
  assign hit = acc && fill >= len - LEN_W'(1) && ((shifted ^ pat) & mask) == '0;
  always_comb begin
    hist_nx = hist;
    fill_nx = fill;
    match_nx = match_q;
    pat_nx = pat;
    len_nx = len;
    ovl_nx = ovl;
    if (bus.cfg_load) begin
      hist_nx = '0;
      fill_nx = '0;
      match_nx = 1'b0;
      pat_nx = bus.cfg_pattern;
      len_nx = cfg_len_c;
      ovl_nx = ovl_e'(bus.cfg_overlap);
    end else if (acc) begin
      hist_nx = shifted;
      match_nx = hit;
      fill_nx = hit ? (ovl == OVL_ON ? len : '0) : (fill == len ? len : fill + LEN_W'(1));
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      match_q <= 1'b0;
      pat <= DEF_PATTERN;
      len <= LEN_W'(DEF_LEN);
      ovl <= ovl_e'(DEF_OVERLAP);
    end else begin
      hist <= hist_nx;
      fill <= fill_nx;
      match_q <= match_nx;
      pat <= pat_nx;
      len <= len_nx;
      ovl <= ovl_nx;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(bus.count_clear),
    .inc(hit),
    .count(bus.match_count)
  );
  assign bus.match = match_q;
  assign bus.Estado = fill;
endmodule
